vga_frame_swap_ctrl: RTL

//  Sequences the pixel-buffer DMA control slave for double-buffered display on sys_clk_clk.

---
 rtl/vga_frame_swap_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vga_frame_swap_ctrl.sv
// rtl/vga_frame_swap_ctrl.sv - double-buffer frame swap sequencer for the pixel-buffer DMA control slave
// Optional feature macro: FRAME_SWAP_TIMEOUT_EN (polling timeout with sticky swap_error)
module vga_frame_swap_ctrl #(
  parameter logic [31:0] INIT_FRONT_ADDR = 32'h0000_0000,
  parameter int          POLL_GAP        = 16,
  parameter int          TIMEOUT_CYCLES  = 2_000_000
) (
  input  logic        sys_clk_clk,
  input  logic        sys_reset_reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        swap_done,
  output logic [31:0] front_addr,
  output logic        busy,
  output logic        swap_error,
  output logic [1:0]  ctrl_address,
  output logic [3:0]  ctrl_byteenable,
  output logic        ctrl_read,
  output logic        ctrl_write,
  output logic [31:0] ctrl_writedata,
  input  logic [31:0] ctrl_readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BACK,
    S_WR_SWAP,
    S_GAP,
    S_RD_STAT,
    S_WAIT_RD,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0]  REG_BUFFER  = 2'd0;
  localparam logic [1:0]  REG_BACKBUF = 2'd1;
  localparam logic [1:0]  REG_STATUS  = 2'd3;
  localparam logic [15:0] GAP_LOAD    = 16'(POLL_GAP - 1);

  state_t      state;
  logic [31:0] pend_addr;
  logic [15:0] poll_cnt;
  logic        stat_bit;

  // Only the swap-pending bit of the status word matters.
  logic unused_rd;
  assign unused_rd = ^ctrl_readdata[31:1];

`ifdef FRAME_SWAP_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wait_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES < 0);
`endif

  // Sequencer: every output is registered so it is valid for the whole state it belongs to.
  always_ff @(posedge sys_clk_clk) begin
    if (sys_reset_reset) begin
      state           <= S_IDLE;
      req_ready       <= 1'b1;
      busy            <= 1'b0;
      swap_done       <= 1'b0;
      swap_error      <= 1'b0;
      ctrl_read       <= 1'b0;
      ctrl_write      <= 1'b0;
      ctrl_address    <= 2'd0;
      ctrl_byteenable <= 4'h0;
      ctrl_writedata  <= 32'h0;
      front_addr      <= INIT_FRONT_ADDR;
      pend_addr       <= 32'h0;
      poll_cnt        <= 16'h0;
      stat_bit        <= 1'b0;
`ifdef FRAME_SWAP_TIMEOUT_EN
      wait_cnt        <= 32'h0;
`endif
    end else begin
      ctrl_read       <= 1'b0;
      ctrl_write      <= 1'b0;
      ctrl_byteenable <= 4'h0;
      swap_done       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            pend_addr       <= req_addr & ~32'h3;
            req_ready       <= 1'b0;
            busy            <= 1'b1;
            ctrl_write      <= 1'b1;
            ctrl_address    <= REG_BACKBUF;
            ctrl_writedata  <= req_addr & ~32'h3;
            ctrl_byteenable <= 4'hF;
            state           <= S_WR_BACK;
          end
        end
        S_WR_BACK: begin
          ctrl_write      <= 1'b1;
          ctrl_address    <= REG_BUFFER;
          ctrl_writedata  <= 32'h0;
          ctrl_byteenable <= 4'hF;
          state           <= S_WR_SWAP;
        end
        S_WR_SWAP: begin
          poll_cnt <= GAP_LOAD;
`ifdef FRAME_SWAP_TIMEOUT_EN
          wait_cnt <= 32'h0;
`endif
          state    <= S_GAP;
        end
        S_GAP: begin
          if (poll_cnt == 16'h0) begin
            ctrl_read       <= 1'b1;
            ctrl_address    <= REG_STATUS;
            ctrl_byteenable <= 4'hF;
            state           <= S_RD_STAT;
          end else begin
            poll_cnt <= poll_cnt - 16'h1;
          end
        end
        S_RD_STAT: begin
          state <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          stat_bit <= ctrl_readdata[0];
          state    <= S_CHECK;
        end
        S_CHECK: begin
          if (stat_bit) begin
            poll_cnt <= GAP_LOAD;
            state    <= S_GAP;
          end else begin
            front_addr <= pend_addr;
            swap_done  <= 1'b1;
            busy       <= 1'b0;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase

`ifdef FRAME_SWAP_TIMEOUT_EN
      // A swap that completes on the final counted cycle still wins over the timeout.
      if (state == S_GAP || state == S_RD_STAT || state == S_WAIT_RD || state == S_CHECK) begin
        wait_cnt <= wait_cnt + 32'h1;
        if (wait_cnt == TO_LAST && !(state == S_CHECK && !stat_bit)) begin
          state           <= S_IDLE;
          req_ready       <= 1'b1;
          busy            <= 1'b0;
          swap_error      <= 1'b1;
          ctrl_read       <= 1'b0;
          ctrl_byteenable <= 4'h0;
        end
      end
`endif
    end
  end

endmodule
